// File: rtl/arbitrated_ram_pkg.sv
// Shared types and helpers for the arbitrated register-file RAM.
package arbitrated_ram_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE   = 1'b0;
    localparam state_t ACCESS = 1'b1;

    // Upper bound on requester count supported by the one-hot helper.
    localparam int MAX_PORTS = 32;

    function automatic logic [MAX_PORTS-1:0] onehot(input int idx);
        return MAX_PORTS'(1) << idx;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbitrated_ram_if.sv
// Request/response bundle between the requesters and arbitrated_ram.
// Carries wstrb only when ARBITRATED_RAM_BYTE_MASK_EN is defined.
interface arbitrated_ram_if #(
    parameter int WIDTH   = 8,
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 5
);
    logic [N_PORTS-1:0]        req;
    logic [N_PORTS-1:0]        we;
    logic [N_PORTS*ADDR_W-1:0] addr;
    logic [N_PORTS*WIDTH-1:0]  wdata;
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
    logic [N_PORTS*(WIDTH/8)-1:0] wstrb;
`endif
    logic [N_PORTS-1:0]        gnt;
    logic [N_PORTS-1:0]        rvalid;
    logic [WIDTH-1:0]          rdata;
    logic                      err;

`ifdef ARBITRATED_RAM_BYTE_MASK_EN
    modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata, err);
`else
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
`endif

endinterface

// File: rtl/arbitrated_ram_rr_arbiter.sv
// Combinational round-robin selector: search starts one past the pointer.
module rr_arbiter
    import arbitrated_ram_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int IW      = idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic [IW-1:0]      winner,
    output logic               any
);

    logic [IW:0] cand;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = {1'b0, pointer} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_PORTS))
                cand = cand - (IW+1)'(N_PORTS);
            if (!any && req[cand[IW-1:0]]) begin
                any    = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/arbitrated_ram.sv
// Single-bank register-file RAM shared by N_PORTS requesters via round-robin.
// Optional per-byte write strobes with ARBITRATED_RAM_BYTE_MASK_EN.
module arbitrated_ram
    import arbitrated_ram_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 32,
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             reset,
    arbitrated_ram_if.slave bus
);

    localparam int IW = idx_w(N_PORTS);
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
    localparam int NB = WIDTH / 8;
`endif

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic               any;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_wdata;

    logic [IW-1:0]      win_p1;
    logic               we_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [WIDTH-1:0]   wdata_p1;
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
    logic [NB-1:0]      sel_wstrb;
    logic [NB-1:0]      wstrb_p1;
`endif

    logic [N_PORTS-1:0] gnt_q;
    logic [N_PORTS-1:0] rvalid_q;
    logic [WIDTH-1:0]   rdata_q;
    logic               err_q;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               oor;
    logic [WIDTH-1:0]   cur_word;
    logic [WIDTH-1:0]   wr_word;

    rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
        .req     (bus.req),
        .pointer (ptr),
        .winner  (win),
        .any     (any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
        sel_wstrb = '0;
`endif
        for (int p = 0; p < N_PORTS; p++) begin
            if (win == IW'(p)) begin
                sel_we    = bus.we[p];
                sel_addr  = bus.addr[p*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[p*WIDTH +: WIDTH];
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
                sel_wstrb = bus.wstrb[p*NB +: NB];
`endif
            end
        end
    end

    // Stage p1: winner's request captured on the grant edge
    always_ff @(posedge clk) begin
        if (state == IDLE && any) begin
            win_p1   <= win;
            we_p1    <= sel_we;
            addr_p1  <= sel_addr;
            wdata_p1 <= sel_wdata;
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
            wstrb_p1 <= sel_wstrb;
`endif
        end
    end

    assign oor      = ({1'b0, addr_p1} >= (ADDR_W+1)'(DEPTH));
    assign cur_word = oor ? '0 : mem[addr_p1];

    always_comb begin
        wr_word = wdata_p1;
`ifdef ARBITRATED_RAM_BYTE_MASK_EN
        for (int b = 0; b < NB; b++) begin
            if (!wstrb_p1[b])
                wr_word[b*8 +: 8] = cur_word[b*8 +: 8];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state == ACCESS && we_p1 && !oor) begin
            mem[addr_p1] <= wr_word;
        end
    end

    // Stage p2: completion pulses, read data and pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= IW'(N_PORTS - 1);
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt_q <= N_PORTS'(onehot(int'(win)));
                        state <= ACCESS;
                    end
                end
                default: begin
                    ptr   <= win_p1;
                    state <= IDLE;
                    err_q <= oor;
                    if (!we_p1) begin
                        rvalid_q <= N_PORTS'(onehot(int'(win_p1)));
                        rdata_q  <= cur_word;
                    end
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

endmodule
